conv_lane_scheduler: RTL

Sequencer for the four-lane convolution array, in which each filter lane owns its own SRAM and all lanes share one coefficient bus. It holds a host-writable kernel bank and, on a single go, broadcasts the kernel taps over fc/fc_valid and pulses start to all lanes. It then tracks each lane's out_valid stream until every lane has produced its full tile, and reports completion. It sits between the host/config logic and the lane array, driving the array's fc, fc_valid and start inputs.

---
 rtl/conv_lane_scheduler_pkg.sv | 18 +
 rtl/conv_lane_scheduler_counter.sv | 37 +++
 rtl/conv_lane_scheduler.sv | 122 ++++++++++++
 3 files changed

// File: rtl/conv_lane_scheduler_pkg.sv
// Shared types and default sizing for the convolution lane scheduler.
package conv_pkg;

  localparam int NUM_LANES = 4;
  localparam int NUM_TAPS  = 9;
  localparam int COEF_W    = 8;

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_DONE
  } state_t;

endpackage

// File: rtl/conv_lane_scheduler_counter.sv
// Per-lane output pixel counter with sticky tile-complete and overrun flags.
module lane_progress_counter #(
  parameter int PIX_PER_LANE = 16384,
  parameter int CNT_W        = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             valid,
  output logic [CNT_W-1:0] count,
  output logic             done,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PIX_PER_LANE - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else if (enable && valid) begin
      if (done) begin
        overrun <= 1'b1;
      end else begin
        count <= count + 1'b1;
        if (count == LAST) done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_lane_scheduler.sv
// Kernel bank + tap broadcast sequencer that tracks per-lane tile completion.
module conv_lane_scheduler #(
  parameter int NUM_LANES    = conv_pkg::NUM_LANES,
  parameter int NUM_TAPS     = conv_pkg::NUM_TAPS,
  parameter int PIX_PER_LANE = 16384,
  parameter int CNT_W        = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [3:0]           cfg_addr,
  input  logic [7:0]           cfg_data,
  input  logic                 go,
  input  logic [NUM_LANES-1:0] lane_valid,
  output logic [7:0]           fc,
  output logic                 fc_valid,
  output logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_LANES-1:0] lane_done,
  output logic                 overrun
);

  import conv_pkg::*;

  localparam int TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIX_PER_LANE - 1);

  state_t           state, state_n;
  logic [TAP_W-1:0] tap, tap_n;
  coef_t            bank [NUM_TAPS];
  coef_t            fc_n;
  logic             fc_valid_n, start_n, done_n, busy_n;
  logic             accept, bank_we, in_run, ovr_ext;
  logic [NUM_LANES-1:0] lane_fin, lane_ovr;
  logic [CNT_W-1:0]     lane_cnt [NUM_LANES];

  assign accept  = (state == S_IDLE) && go;
  assign bank_we = (state == S_IDLE) && cfg_we && (int'(cfg_addr) < NUM_TAPS);
  assign in_run  = (state == S_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_TAPS; i++) bank[i] <= '0;
    end else if (bank_we) begin
      bank[cfg_addr[TAP_W-1:0]] <= cfg_data;
    end
  end

  // Lane counts as finished on the edge that delivers its last pixel.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_progress_counter #(
      .PIX_PER_LANE(PIX_PER_LANE),
      .CNT_W       (CNT_W)
    ) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (accept),
      .enable (in_run),
      .valid  (lane_valid[i]),
      .count  (lane_cnt[i]),
      .done   (lane_done[i]),
      .overrun(lane_ovr[i])
    );
    assign lane_fin[i] = lane_done[i] || (lane_valid[i] && (lane_cnt[i] == LAST_PIX));
  end

  always_comb begin
    state_n = state;
    tap_n   = tap;
    unique case (state)
      S_IDLE:  if (go) begin
                 state_n = S_LOAD;
                 tap_n   = '0;
               end
      S_LOAD:  if (tap == LAST_TAP) state_n = S_START;
               else                 tap_n   = tap + 1'b1;
      S_START: state_n = S_RUN;
      S_RUN:   if (&lane_fin) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Outputs are registered from next state; a same-cycle bank write forwards into tap 0.
    fc_valid_n = (state_n == S_LOAD);
    fc_n       = '0;
    if (fc_valid_n) begin
      if (bank_we && (int'(cfg_addr) == int'(tap_n))) fc_n = coef_t'(cfg_data);
      else                                            fc_n = bank[tap_n];
    end
    start_n = (state_n == S_START);
    done_n  = (state_n == S_DONE);
    busy_n  = (state_n != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tap      <= '0;
      fc       <= '0;
      fc_valid <= 1'b0;
      start    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovr_ext  <= 1'b0;
    end else begin
      state    <= state_n;
      tap      <= tap_n;
      fc       <= fc_n;
      fc_valid <= fc_valid_n;
      start    <= start_n;
      busy     <= busy_n;
      done     <= done_n;
      if (accept)                       ovr_ext <= 1'b0;
      else if (!in_run && |lane_valid)  ovr_ext <= 1'b1;
    end
  end

  assign overrun = ovr_ext || (|lane_ovr);

endmodule
